wb_tag_arb_rr: RTL and testbench

WB_TAG_ARB_RR -- requirements
Module: wb_tag_arb_rr

---
 rtl/wb_tag_arb_rr.sv | 175 +++++++++++++++++
 tb/tb_wb_tag_arb_rr.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/wb_tag_arb_rr.sv
// wb_tag_arb_rr -- round-robin Wishbone bus arbiter with per-initiator
// lock (cyc) hold and an optional stalled-grant watchdog.
//
// Parameters:
//   N_REQ          number of requesting initiators (1..16)
//   TIMEOUT_CYCLES stalled-grant cycles before a forced release (>=2)
//
// Ports:
//   clock        single clock, all state updates on its rising edge
//   reset        synchronous active-high reset
//   req          per-initiator cyc&&stb request
//   lock         per-initiator cyc; keeps the grant across beats
//   ack, err     target acknowledge / error (only used by the watchdog)
//   gnt          registered one-hot grant
//   gnt_id       index of the granted initiator (holds its value in IDLE)
//   gnt_valid    high while a grant is held; qualifies gnt_id
//   timeout_err  one-cycle pulse on a watchdog forced release
//
// Build option: define WB_TAG_ARB_TIMEOUT_EN to build the stall watchdog.
// Without it no counter exists, timeout_err is tied low and a locked grant
// is held for as long as the initiator keeps lock high.

module wb_tag_arb_rr #(
  parameter int N_REQ          = 2,
  parameter int TIMEOUT_CYCLES = 255,
  localparam int ID_W          = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] lock,
  input  logic             ack,
  input  logic             err,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             gnt_valid,
  output logic             timeout_err
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t           state_reg, state_next;
  logic [N_REQ-1:0] gnt_reg, gnt_next;
  logic [ID_W-1:0]  gnt_id_reg, gnt_id_next;
  logic [ID_W-1:0]  last_id_reg, last_id_next;

  logic             lock_cur;
  logic             req_cur;
  logic             tmo_fire;

  // gnt_reg is one-hot while granted, so masking avoids a variable index.
  assign lock_cur = |(lock & gnt_reg);
  assign req_cur  = |(req & gnt_reg);

  // Round-robin pick: requests strictly above last_id take precedence
  // (lowest such index wins); if none, wrap and take the lowest request.
  logic [N_REQ-1:0] above_mask;
  logic [N_REQ-1:0] req_hi;
  logic [N_REQ:0]   lower_hi;
  logic [N_REQ:0]   lower_all;
  logic [N_REQ-1:0] pick_hi;
  logic [N_REQ-1:0] pick_all;
  logic [N_REQ-1:0] win_onehot;
  logic [ID_W-1:0]  id_acc [N_REQ+1];
  logic [ID_W-1:0]  win_id;

  assign lower_hi[0]  = 1'b0;
  assign lower_all[0] = 1'b0;
  assign id_acc[0]    = '0;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_pick
    assign above_mask[gi]  = (ID_W'(gi) > last_id_reg);
    assign req_hi[gi]      = req[gi] & above_mask[gi];
    assign lower_hi[gi+1]  = lower_hi[gi] | req_hi[gi];
    assign lower_all[gi+1] = lower_all[gi] | req[gi];
    assign pick_hi[gi]     = req_hi[gi] & ~lower_hi[gi];
    assign pick_all[gi]    = req[gi] & ~lower_all[gi];
    assign id_acc[gi+1]    = id_acc[gi] | (win_onehot[gi] ? ID_W'(gi) : '0);
  end

  assign win_onehot = lower_hi[N_REQ] ? pick_hi : pick_all;
  assign win_id     = id_acc[N_REQ];

  // Next-state logic. Leaving GRANT always lands in IDLE for at least one
  // cycle, which gives the mandatory gap between consecutive grants.
  always_comb begin
    state_next   = state_reg;
    gnt_next     = gnt_reg;
    gnt_id_next  = gnt_id_reg;
    last_id_next = last_id_reg;
    case (state_reg)
      IDLE: begin
        if (|req) begin
          state_next   = GRANT;
          gnt_next     = win_onehot;
          gnt_id_next  = win_id;
          last_id_next = win_id;
        end
      end
      GRANT: begin
        if (tmo_fire || !lock_cur) begin
          state_next = IDLE;
          gnt_next   = '0;
        end
      end
      default: begin
        state_next = IDLE;
        gnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg   <= IDLE;
      gnt_reg     <= '0;
      gnt_id_reg  <= '0;
      last_id_reg <= ID_W'(N_REQ - 1);  // initiator 0 first after reset
    end else begin
      state_reg   <= state_next;
      gnt_reg     <= gnt_next;
      gnt_id_reg  <= gnt_id_next;
      last_id_reg <= last_id_next;
    end
  end

  assign gnt       = gnt_reg;
  assign gnt_id    = gnt_id_reg;
  assign gnt_valid = (state_reg == GRANT);

`ifdef WB_TAG_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] stall_cnt_reg, stall_cnt_next;
  logic             timeout_err_reg;
  logic             stalled;

  // A cycle counts as stalled only while the owner still requests and the
  // target has answered with neither ack nor err; ack/err on the final
  // count therefore pre-empts the release.
  assign stalled  = (state_reg == GRANT) && req_cur && !ack && !err;
  assign tmo_fire = stalled && (stall_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    stall_cnt_next = stall_cnt_reg;
    if (state_reg == IDLE) begin
      stall_cnt_next = '0;             // guarantees a clean count on entry
    end else if (ack || err || tmo_fire) begin
      stall_cnt_next = '0;
    end else if (req_cur) begin
      stall_cnt_next = stall_cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt_reg   <= '0;
      timeout_err_reg <= 1'b0;
    end else begin
      stall_cnt_reg   <= stall_cnt_next;
      timeout_err_reg <= tmo_fire;
    end
  end

  assign timeout_err = timeout_err_reg;
`else
  assign tmo_fire    = 1'b0;
  assign timeout_err = 1'b0;

  // ack/err and the owner's req only matter to the watchdog.
  logic unused_tmo_sigs;
  assign unused_tmo_sigs = ^{ack, err, req_cur, (TIMEOUT_CYCLES > 1)};
`endif

endmodule

// File: tb/tb_wb_tag_arb_rr.sv
// Directed testbench for wb_tag_arb_rr (N_REQ=4, TIMEOUT_CYCLES=8).
// Each step drives one cycle of inputs, queues the expected registered
// outputs, and compares them one cycle later. Watchdog steps are selected
// by WB_TAG_ARB_TIMEOUT_EN, matching the RTL build.

module tb_wb_tag_arb_rr;

  localparam int N  = 4;
  localparam int TO = 8;

  logic         clock = 1'b0;
  logic         reset;
  logic [N-1:0] req;
  logic [N-1:0] lock;
  logic         ack;
  logic         err;
  logic [N-1:0] gnt;
  logic [1:0]   gnt_id;
  logic         gnt_valid;
  logic         timeout_err;

  typedef struct packed {
    logic [N-1:0] gnt;
    logic [1:0]   id;
    logic         valid;
    logic         tmo;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clock = ~clock;

  wb_tag_arb_rr #(
    .N_REQ          (N),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .req         (req),
    .lock        (lock),
    .ack         (ack),
    .err         (err),
    .gnt         (gnt),
    .gnt_id      (gnt_id),
    .gnt_valid   (gnt_valid),
    .timeout_err (timeout_err)
  );

  task automatic step(input string tag, input logic rst,
                      input logic [N-1:0] r, input logic [N-1:0] l,
                      input logic a, input logic e,
                      input logic [N-1:0] eg, input logic [1:0] eid,
                      input logic ev, input logic et);
    exp_t exp_v;
    reset = rst;
    req   = r;
    lock  = l;
    ack   = a;
    err   = e;
    sb_q.push_back(exp_t'{eg, eid, ev, et});
    @(posedge clock);
    #1;
    exp_v = sb_q.pop_front();
    checks++;
    assert (gnt === exp_v.gnt) else begin
      errors++;
      $error("FAIL %s gnt: observed=%b expected=%b", tag, gnt, exp_v.gnt);
    end
    checks++;
    assert (gnt_id === exp_v.id) else begin
      errors++;
      $error("FAIL %s gnt_id: observed=%0d expected=%0d", tag, gnt_id, exp_v.id);
    end
    checks++;
    assert (gnt_valid === exp_v.valid) else begin
      errors++;
      $error("FAIL %s gnt_valid: observed=%b expected=%b", tag, gnt_valid, exp_v.valid);
    end
    checks++;
    assert (timeout_err === exp_v.tmo) else begin
      errors++;
      $error("FAIL %s timeout_err: observed=%b expected=%b", tag, timeout_err, exp_v.tmo);
    end
    $display("%-12s rst=%b req=%b lock=%b ack=%b err=%b -> gnt=%b id=%0d v=%b tmo=%b",
             tag, rst, r, l, a, e, gnt, gnt_id, gnt_valid, timeout_err);
  endtask

  initial begin
    reset = 1'b1;
    req   = '0;
    lock  = '0;
    ack   = 1'b0;
    err   = 1'b0;

    // Reset state
    step("reset0", 1, 4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 0, 0);
    step("reset1", 1, 4'b1111, 4'b1111, 1, 1, 4'b0000, 0, 0, 0);

    // Single request, one-cycle latency, lock holds, release, id holds
    step("basic_gnt",  0, 4'b1010, 4'b1010, 0, 0, 4'b0010, 1, 1, 0);
    step("basic_hold", 0, 4'b1010, 4'b1010, 0, 0, 4'b0010, 1, 1, 0);
    step("basic_rel",  0, 4'b0000, 4'b0000, 0, 0, 4'b0000, 1, 0, 0);
    step("idle_ackerr",0, 4'b0000, 4'b0000, 1, 1, 4'b0000, 1, 0, 0);

    // Fairness after reset: 0,1,2,3,0 with an IDLE cycle between grants
    step("fair_rst",  1, 4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 0, 0);
    step("fair_g0",   0, 4'b1111, 4'b1111, 0, 0, 4'b0001, 0, 1, 0);
    step("fair_i0",   0, 4'b1111, 4'b1110, 0, 0, 4'b0000, 0, 0, 0);
    step("fair_g1",   0, 4'b1111, 4'b1111, 0, 0, 4'b0010, 1, 1, 0);
    step("fair_i1",   0, 4'b1111, 4'b1101, 0, 0, 4'b0000, 1, 0, 0);
    step("fair_g2",   0, 4'b1111, 4'b1111, 0, 0, 4'b0100, 2, 1, 0);
    step("fair_i2",   0, 4'b1111, 4'b1011, 0, 0, 4'b0000, 2, 0, 0);
    step("fair_g3",   0, 4'b1111, 4'b1111, 0, 0, 4'b1000, 3, 1, 0);
    step("fair_i3",   0, 4'b1111, 4'b0111, 0, 0, 4'b0000, 3, 0, 0);
    step("fair_g0b",  0, 4'b1111, 4'b1111, 0, 0, 4'b0001, 0, 1, 0);
    step("fair_done", 0, 4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 0, 0);

    // Burst: lock[2] held through acks/err while req[0] waits
    step("burst_gnt",  0, 4'b0101, 4'b0100, 0, 0, 4'b0100, 2, 1, 0);
    step("burst_ack1", 0, 4'b0101, 4'b0100, 1, 0, 4'b0100, 2, 1, 0);
    step("burst_ack2", 0, 4'b0101, 4'b0100, 1, 0, 4'b0100, 2, 1, 0);
    step("burst_err",  0, 4'b0101, 4'b0100, 0, 1, 4'b0100, 2, 1, 0);
    step("burst_ack3", 0, 4'b0101, 4'b0100, 1, 0, 4'b0100, 2, 1, 0);
    step("burst_rel",  0, 4'b0001, 4'b0000, 0, 0, 4'b0000, 2, 0, 0);
    step("burst_next", 0, 4'b0001, 4'b0001, 0, 0, 4'b0001, 0, 1, 0);
    step("burst_done", 0, 4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 0, 0);

`ifdef WB_TAG_ARB_TIMEOUT_EN
    // Stalled grant: forced release 8 cycles after gnt rises
    step("to_gnt", 0, 4'b0010, 4'b0010, 0, 0, 4'b0010, 1, 1, 0);
    for (int i = 1; i <= TO - 1; i++)
      step($sformatf("to_stall%0d", i), 0, 4'b0010, 4'b0010, 0, 0, 4'b0010, 1, 1, 0);
    step("to_fire",  0, 4'b0010, 4'b0010, 0, 0, 4'b0000, 1, 0, 1);
    step("to_regnt", 0, 4'b0010, 4'b0010, 0, 0, 4'b0010, 1, 1, 0);
    for (int i = 1; i <= TO - 2; i++)
      step($sformatf("to_s%0d", i), 0, 4'b0010, 4'b0010, 0, 0, 4'b0010, 1, 1, 0);
    // ack on the 7th stalled cycle wins and clears the count
    step("to_ack", 0, 4'b0010, 4'b0010, 1, 0, 4'b0010, 1, 1, 0);
    for (int i = 1; i <= 4; i++)
      step($sformatf("to_a%0d", i), 0, 4'b0010, 4'b0010, 0, 0, 4'b0010, 1, 1, 0);
    // owner drops req but keeps lock: count holds
    for (int i = 1; i <= 3; i++)
      step($sformatf("to_hold%0d", i), 0, 4'b0000, 4'b0010, 0, 0, 4'b0010, 1, 1, 0);
    for (int i = 1; i <= 3; i++)
      step($sformatf("to_b%0d", i), 0, 4'b0010, 4'b0010, 0, 0, 4'b0010, 1, 1, 0);
    step("to_fire2", 0, 4'b0010, 4'b0010, 0, 0, 4'b0000, 1, 0, 1);
    step("to_rel",   0, 4'b0000, 4'b0000, 0, 0, 4'b0000, 1, 0, 0);
`else
    // No watchdog: a stalled locked grant is held indefinitely
    step("st_gnt", 0, 4'b0010, 4'b0010, 0, 0, 4'b0010, 1, 1, 0);
    for (int i = 1; i <= 50; i++)
      step($sformatf("st_stall%0d", i), 0, 4'b0010, 4'b0010, 0, 0, 4'b0010, 1, 1, 0);
    step("st_rel", 0, 4'b0000, 4'b0000, 0, 0, 4'b0000, 1, 0, 0);
`endif

    // Reset during a locked grant: drops gnt, zeroes gnt_id, restores priority
    step("rst_gnt",    0, 4'b0010, 4'b0010, 0, 0, 4'b0010, 1, 1, 0);
    step("rst_hold",   0, 4'b0010, 4'b0010, 0, 0, 4'b0010, 1, 1, 0);
    step("rst_assert", 1, 4'b0010, 4'b0010, 0, 0, 4'b0000, 0, 0, 0);
    step("rst_prio",   0, 4'b0110, 4'b0110, 0, 0, 4'b0010, 1, 1, 0);
    step("rst_rel",    0, 4'b0000, 4'b0000, 0, 0, 4'b0000, 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
